matrix_scan_ctrl: RTL and testbench

Time-multiplexed scan scheduler for the board's 5x7 LED dot matrix and 7-segment digit, which share the column and line drive budget. It cycles through six display slots: matrix columns c0..c4, then the 7-segment digit. It drives exactly one slot at a time, using registered outputs with optional blanking between slots. It double-buffers a 35-bit matrix frame behind a valid/ready handshake, so the rest of the design can update the image without tearing. It sits between the switch/decoder logic and the physical display pins.

---
 rtl/scan_pkg.sv | 40 ++++
 rtl/scan_prescaler.sv | 35 +++
 rtl/matrix_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_matrix_scan_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the LED matrix / 7-segment scan controller.
package scan_pkg;

   localparam int NUM_COLS  = 5;
   localparam int NUM_LINES = 7;
   localparam int NUM_SLOTS = 6;

   typedef enum logic [2:0] {
      SLOT_C0  = 3'd0,
      SLOT_C1  = 3'd1,
      SLOT_C2  = 3'd2,
      SLOT_C3  = 3'd3,
      SLOT_C4  = 3'd4,
      SLOT_SEG = 3'(NUM_SLOTS - 1)
   } slot_t;

   localparam logic [2:0] SEG_SLOT = 3'd5;

   typedef logic [NUM_COLS*NUM_LINES-1:0] frame_t;

   localparam logic [NUM_COLS-1:0]  COL_OFF  = 5'b11111;
   localparam logic [NUM_LINES-1:0] LINE_OFF = '0;
   localparam logic [7:0]           SEG_OFF  = '0;

   // Column c of a frame occupies bits [7c+6:7c].
   function automatic logic [NUM_LINES-1:0] frame_col(input frame_t f, input slot_t s);
      logic [NUM_LINES-1:0] col;
      col = LINE_OFF;
      case (s)
         SLOT_C0: col = f[6:0];
         SLOT_C1: col = f[13:7];
         SLOT_C2: col = f[20:14];
         SLOT_C3: col = f[27:21];
         SLOT_C4: col = f[34:28];
         default: col = LINE_OFF;
      endcase
      return col;
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot-length prescaler: counts 0..PRESCALE-1 while enabled and flags the wrap cycle.
module scan_prescaler #(
   parameter int PRESCALE = 50000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   output logic [$clog2(PRESCALE)-1:0] count,
   output logic                        wrap
);

   localparam int CW = $clog2(PRESCALE);
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      wrap    = en && (count_q == LAST);
      count_d = count_q;
      if (en) begin
         count_d = wrap ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Six-slot scan scheduler for the 5x7 matrix and 7-segment digit with a double-buffered frame.
// Define SCAN_BLANK_EN to blank all drives for BLANK cycles at the start of every slot.
module matrix_scan_ctrl
   import scan_pkg::*;
#(
   parameter int PRESCALE = 50000,
   parameter int BLANK    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 frame_valid,
   output logic                 frame_ready,
   input  logic [34:0]          frame_cols,
   input  logic [7:0]           seg_in,
   output logic [NUM_COLS-1:0]  col_n,
   output logic [NUM_LINES-1:0] line,
   output logic [7:0]           seg,
   output logic                 disp_mtx,
   output logic                 disp_seg,
   output logic [2:0]           slot,
   output logic                 frame_done
);

   localparam int CW = $clog2(PRESCALE);

   logic [CW-1:0] count;
   logic          wrap;

   scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .count (count),
      .wrap  (wrap)
   );

   slot_t  slot_q, slot_d;
   frame_t active_q, active_d;
   frame_t shadow_q, shadow_d;
   logic   pending_q, pending_d;
   logic   swap_q, swap_d;
   logic   accept, blank;

   logic [NUM_COLS-1:0]  col_n_q, col_n_d;
   logic [NUM_LINES-1:0] line_q, line_d;
   logic [7:0]           seg_q, seg_d;
   logic                 disp_mtx_q, disp_mtx_d;
   logic                 disp_seg_q, disp_seg_d;
   slot_t                slot_out_q;
   logic                 frame_done_q;

   // Slot FSM and frame buffering; the swap only happens at the end of a full scan.
   always_comb begin
      slot_d    = slot_q;
      active_d  = active_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      accept    = frame_valid && !pending_q;
      swap_d    = wrap && (slot_q == SEG_SLOT) && pending_q;
      if (wrap) begin
         case (slot_q)
            SLOT_C0:  slot_d = SLOT_C1;
            SLOT_C1:  slot_d = SLOT_C2;
            SLOT_C2:  slot_d = SLOT_C3;
            SLOT_C3:  slot_d = SLOT_C4;
            SLOT_C4:  slot_d = SLOT_SEG;
            SLOT_SEG: slot_d = SLOT_C0;
            default:  slot_d = SLOT_C0;
         endcase
      end
      if (swap_d) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
      if (accept) begin
         shadow_d  = frame_cols;
         pending_d = 1'b1;
      end
   end

`ifdef SCAN_BLANK_EN
   always_comb begin
      blank = !en || (count < CW'(BLANK));
   end
`else
   localparam int unused_blank = BLANK;
   logic unused_count;
   assign unused_count = ^count;

   always_comb begin
      blank = !en;
   end
`endif

   // Drive values for the current slot; they land in the output registers one cycle later.
   always_comb begin
      col_n_d    = COL_OFF;
      line_d     = LINE_OFF;
      seg_d      = SEG_OFF;
      disp_mtx_d = 1'b0;
      disp_seg_d = 1'b0;
      if (!blank) begin
         if (slot_q == SEG_SLOT) begin
            seg_d      = seg_in;
            disp_seg_d = 1'b1;
         end else begin
            col_n_d    = ~(NUM_COLS'(1) << slot_q);
            line_d     = frame_col(active_q, slot_q);
            disp_mtx_d = 1'b1;
         end
      end
   end

   // swap_q delays frame_done so it lines up with the first registered slot-0 drive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q       <= SLOT_C0;
         active_q     <= '0;
         shadow_q     <= '0;
         pending_q    <= 1'b0;
         swap_q       <= 1'b0;
         col_n_q      <= COL_OFF;
         line_q       <= LINE_OFF;
         seg_q        <= SEG_OFF;
         disp_mtx_q   <= 1'b0;
         disp_seg_q   <= 1'b0;
         slot_out_q   <= SLOT_C0;
         frame_done_q <= 1'b0;
      end else begin
         slot_q       <= slot_d;
         active_q     <= active_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         swap_q       <= swap_d;
         col_n_q      <= col_n_d;
         line_q       <= line_d;
         seg_q        <= seg_d;
         disp_mtx_q   <= disp_mtx_d;
         disp_seg_q   <= disp_seg_d;
         slot_out_q   <= slot_q;
         frame_done_q <= swap_q;
      end
   end

   assign frame_ready = !pending_q;
   assign col_n       = col_n_q;
   assign line        = line_q;
   assign seg         = seg_q;
   assign disp_mtx    = disp_mtx_q;
   assign disp_seg    = disp_seg_q;
   assign slot        = slot_out_q;
   assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl: a phase-based reference model checked every cycle,
// plus directed scenarios (first frame, handshake, back-pressure, freeze, async reset) and random traffic.
module tb_matrix_scan_ctrl;

   localparam int P  = 4;
   localparam int BL = 1;
`ifdef SCAN_BLANK_EN
   localparam int EB = BL;
`else
   localparam int EB = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        frame_valid = 1'b0;
   logic [34:0] frame_cols = '0;
   logic [7:0]  seg_in = 8'h3F;
   logic        frame_ready;
   logic [4:0]  col_n;
   logic [6:0]  line;
   logic [7:0]  seg;
   logic        disp_mtx;
   logic        disp_seg;
   logic [2:0]  slot;
   logic        frame_done;

   always #5 clk = ~clk;

   matrix_scan_ctrl #(.PRESCALE(P), .BLANK(BL)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .frame_cols  (frame_cols),
      .seg_in      (seg_in),
      .col_n       (col_n),
      .line        (line),
      .seg         (seg),
      .disp_mtx    (disp_mtx),
      .disp_seg    (disp_seg),
      .slot        (slot),
      .frame_done  (frame_done)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;

   // Reference model: scan position is just the number of enabled cycles since reset.
   int          phase;
   bit          m_pending;
   logic [34:0] m_shadow, m_active;
   bit          m_swap_d;
   logic [4:0]  exp_col_n;
   logic [6:0]  exp_line;
   logic [7:0]  exp_seg;
   logic        exp_mtx, exp_dseg, exp_ready, exp_done;
   logic [2:0]  exp_slot;

   function automatic int mSlot();
      return (phase / P) % 6;
   endfunction

   function automatic int mCount();
      return phase % P;
   endfunction

   task automatic modelReset();
      phase     = 0;
      m_pending = 0;
      m_shadow  = '0;
      m_active  = '0;
      m_swap_d  = 0;
      exp_col_n = 5'b11111;
      exp_line  = '0;
      exp_seg   = '0;
      exp_mtx   = 0;
      exp_dseg  = 0;
      exp_ready = 1;
      exp_done  = 0;
      exp_slot  = '0;
   endtask

   task automatic modelStep();
      int         c, s;
      logic [4:0] onehot;
      bit         acc, swp;
      c = mCount();
      s = mSlot();
      exp_col_n = 5'b11111;
      exp_line  = '0;
      exp_seg   = '0;
      exp_mtx   = 0;
      exp_dseg  = 0;
      exp_slot  = 3'(s);
      if (en && c >= EB) begin
         if (s == 5) begin
            exp_seg  = seg_in;
            exp_dseg = 1;
         end else begin
            onehot    = 5'b00001 << s;
            exp_col_n = ~onehot;
            exp_line  = m_active[7*s +: 7];
            exp_mtx   = 1;
         end
      end
      exp_done = m_swap_d;
      acc = frame_valid && !m_pending;
      swp = en && (c == P - 1) && (s == 5) && m_pending;
      m_swap_d = swp;
      if (swp) begin
         m_active  = m_shadow;
         m_pending = 0;
      end
      if (acc) begin
         m_shadow  = frame_cols;
         m_pending = 1;
      end
      if (en) phase++;
      exp_ready = !m_pending;
   endtask

   always @(posedge clk) begin
      #1;
      if (!rst_n) modelReset();
      else        modelStep();
   end

   task automatic check1(input string name, input logic [34:0] act, input logic [34:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
      end
   endtask

   task automatic checkOutput();
      check1("col_n",       35'(col_n),       35'(exp_col_n));
      check1("line",        35'(line),        35'(exp_line));
      check1("seg",         35'(seg),         35'(exp_seg));
      check1("disp_mtx",    35'(disp_mtx),    35'(exp_mtx));
      check1("disp_seg",    35'(disp_seg),    35'(exp_dseg));
      check1("slot",        35'(slot),        35'(exp_slot));
      check1("frame_ready", 35'(frame_ready), 35'(exp_ready));
      check1("frame_done",  35'(frame_done),  35'(exp_done));
   endtask

   always @(negedge clk) begin
      if (chk_on) checkOutput();
   end

   task automatic applyStimulus(input logic e, input logic v, input logic [34:0] cols,
                                input logic [7:0] sg);
      @(negedge clk);
      en          = e;
      frame_valid = v;
      frame_cols  = cols;
      seg_in      = sg;
   endtask

   task automatic tick();
      applyStimulus(en, frame_valid, frame_cols, 8'($urandom));
   endtask

   task automatic waitPhase(input int s, input int c, input int budget, input string name,
                            output int used);
      used = 0;
      while (!(mSlot() == s && (c < 0 || mCount() == c)) && used < budget) begin
         tick();
         used++;
      end
      check1(name, 35'(mSlot() == s && (c < 0 || mCount() == c)), 35'd1);
   endtask

   task automatic waitDone(input int budget, input string name);
      int i;
      for (i = 0; i < budget && frame_done !== 1'b1; i++) tick();
      check1(name, 35'(frame_done), 35'd1);
   endtask

   task automatic waitLine0(input logic [6:0] lit, input string name);
      int i;
      for (i = 0; i < 8 && !(slot == 3'd0 && disp_mtx === 1'b1); i++) tick();
      check1(name, 35'(line), 35'(lit));
   endtask

   initial begin
      #100000;
      n_fail++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1, "[TB] watchdog");
   end

   logic [4:0] cols_seen [24];
   logic [7:0] segs_seen [24];
   logic [4:0] col_lit [5] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};

   initial begin
      int          used, cnt, segcnt;
      int          first [5];
      logic [63:0] r;

      modelReset();
      @(posedge clk);
      chk_on = 1'b1;
      @(negedge clk);
      check1("reset_col_n", 35'(col_n), 35'h1F);
      check1("reset_ready", 35'(frame_ready), 35'd1);
      rst_n = 1'b1;
      en    = 1'b1;

      // First frame after reset with no image loaded.
      for (int k = 0; k < 24; k++) begin
         applyStimulus(1'b1, 1'b0, '0, 8'h3F);
         cols_seen[k] = col_n;
         segs_seen[k] = seg;
      end
      segcnt = 0;
      for (int k = 0; k < 24; k++) if (segs_seen[k] == 8'h3F) segcnt++;
      check1("first_frame_seg_cycles", 35'(segcnt), 35'(P - EB));
      for (int s = 0; s < 5; s++) begin
         cnt      = 0;
         first[s] = -1;
         for (int k = 0; k < 24; k++) begin
            if (cols_seen[k] == col_lit[s]) begin
               cnt++;
               if (first[s] < 0) first[s] = k;
            end
         end
         check1($sformatf("first_frame_col%0d_cycles", s), 35'(cnt), 35'(P - EB));
         if (s > 0) check1($sformatf("first_frame_col%0d_order", s), 35'(first[s] > first[s-1]), 35'd1);
      end

      // Handshake mid-frame, then back-pressure on a second frame.
      waitPhase(2, -1, 40, "wait_slot2", used);
      frame_valid = 1'b1;
      frame_cols  = 35'h1_2345_6789;
      tick();
      frame_cols  = 35'h5_5555_5555;
      tick();
      check1("ready_drop", 35'(frame_ready), 35'd0);
      waitDone(6 * P + 4, "frame_done_first");
      tick();
      check1("frame_done_one_cycle", 35'(frame_done), 35'd0);
      check1("second_frame_pending", 35'(frame_ready), 35'd0);
      waitLine0(7'h09, "first_frame_line0");
      frame_valid = 1'b0;
      waitDone(6 * P + 4, "frame_done_second");
      waitLine0(7'h55, "second_frame_line0");

      // Enable freeze in slot 3, count 2.
      waitPhase(3, 2, 40, "wait_slot3_cnt2", used);
      en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         check1("freeze_slot", 35'(slot), 35'd3);
         check1("freeze_col_n", 35'(col_n), 35'h1F);
      end
      en = 1'b1;
      waitPhase(4, 0, 20, "resume_slot4", used);
      check1("resume_remaining_cycles", 35'(used), 35'(P - 2));

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         r = {$urandom, $urandom};
         applyStimulus(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) == 0),
                       r[34:0], 8'($urandom));
      end

      // Asynchronous reset in slot 4 with a frame pending.
      en          = 1'b1;
      frame_valid = 1'b1;
      r           = {$urandom, $urandom};
      frame_cols  = r[34:0] | 35'h1;
      used = 0;
      while (!(m_pending && mSlot() == 4) && used < 60) begin
         tick();
         used++;
         frame_valid = !m_pending;
      end
      check1("wait_pending_slot4", 35'(m_pending && mSlot() == 4), 35'd1);
      frame_valid = 1'b0;
      #2 rst_n = 1'b0;
      modelReset();
      #1;
      check1("async_col_n",      35'(col_n),      35'h1F);
      check1("async_line",       35'(line),       35'd0);
      check1("async_seg",        35'(seg),        35'd0);
      check1("async_disp_mtx",   35'(disp_mtx),   35'd0);
      check1("async_disp_seg",   35'(disp_seg),   35'd0);
      check1("async_slot",       35'(slot),       35'd0);
      check1("async_ready",      35'(frame_ready), 35'd1);
      check1("async_frame_done", 35'(frame_done), 35'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 60; k++) tick();
      check1("post_reset_ready", 35'(frame_ready), 35'd1);

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
